aes_ct_collector: RTL and testbench

//  Downstream neighbour of the pipelined AES encryptor. The encryptor emits no output valid,
//  so this block tracks in-flight blocks from the enable that launched them. It captures each

---
 rtl/aes_ct_collector_pkg.sv | 12 +
 rtl/aes_ct_fifo.sv | 41 ++++
 rtl/aes_ct_collector.sv | 86 ++++++++
 tb/tb_aes_ct_collector.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ct_collector_pkg.sv
// Shared widths and latency for the AES ciphertext collector and its FIFO.
package aes_ct_collector_pkg;
    localparam int AES_BLOCK_W     = 128;
    localparam int AES_ENC_LATENCY = 11;
    localparam int AES_WORD_W      = 32;
    localparam int AES_CT_DEPTH    = 4;

    // Index width that stays legal when there is only one entry.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/aes_ct_fifo.sv
// Synchronous block FIFO with a combinational head read; the caller guarantees no push when full
// unless a pop happens on the same edge.
module aes_ct_fifo
    import aes_ct_collector_pkg::*;
#(
    parameter int W     = AES_BLOCK_W,
    parameter int DEPTH = AES_CT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);
    localparam int AW = idx_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/aes_ct_collector.sv
// Tracks in-flight AES blocks from their launch enable, buffers finished ciphertexts and
// streams them out as MSB-first words, with an advisory credit signal back to the source.
module aes_ct_collector
    import aes_ct_collector_pkg::*;
#(
    parameter int BLOCK_LENGTH = AES_BLOCK_W,
    parameter int WORD_W       = AES_WORD_W,
    parameter int LATENCY      = AES_ENC_LATENCY,
    parameter int DEPTH        = AES_CT_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    blk_en,
    input  logic [BLOCK_LENGTH-1:0] ct_in,
    output logic                    blk_ready,
    output logic [WORD_W-1:0]       m_data,
    output logic                    m_valid,
    output logic                    m_last,
    input  logic                    m_ready,
    input  logic                    ovf_clr,
    output logic                    ovf_flag,
    output logic [7:0]              ovf_cnt
);
    localparam int NW  = BLOCK_LENGTH / WORD_W;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int IFW = $clog2(LATENCY + 1);
    localparam int WIW = idx_w(NW);
    localparam logic [WIW-1:0] LAST_W  = WIW'(NW - 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [LATENCY-1:0]      vpipe;
    logic [IFW-1:0]          in_flight;
    logic [CW-1:0]           fifo_count;
    logic [BLOCK_LENGTH-1:0] head;
    logic [WIW-1:0]          widx;
    logic                    push_req, push_ok, drop, word_acc, block_pop;

    assign push_req  = vpipe[LATENCY-1];
    assign m_valid   = (fifo_count != '0);
    assign word_acc  = m_valid && m_ready;
    assign block_pop = word_acc && (widx == LAST_W);
    // A full FIFO still takes the block when the head leaves on the same edge.
    assign push_ok   = push_req && ((fifo_count < DEPTH_C) || block_pop);
    assign drop      = push_req && !push_ok;
    assign blk_ready = (32'(fifo_count) + 32'(in_flight)) < 32'(DEPTH);
    assign m_last    = m_valid && (widx == LAST_W);
    assign m_data    = m_valid ? head[BLOCK_LENGTH-1-int'(widx)*WORD_W -: WORD_W] : '0;

    aes_ct_fifo #(.W(BLOCK_LENGTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .din   (ct_in),
        .pop   (block_pop),
        .count (fifo_count),
        .head  (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpipe     <= '0;
            in_flight <= '0;
            widx      <= '0;
        end else begin
            vpipe <= (vpipe << 1) | LATENCY'(blk_en);
            if (blk_en && !push_req)      in_flight <= in_flight + IFW'(1);
            else if (push_req && !blk_en) in_flight <= in_flight - IFW'(1);
            if (word_acc) widx <= (widx == LAST_W) ? '0 : widx + 1'b1;
        end
    end

    // A drop on the same edge as a clear leaves a fresh count of one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
        end else if (drop) begin
            ovf_flag <= 1'b1;
            if (ovf_clr)                ovf_cnt <= 8'd1;
            else if (ovf_cnt != 8'hFF)  ovf_cnt <= ovf_cnt + 8'd1;
        end else if (ovf_clr) begin
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
        end
    end
endmodule

// File: tb/tb_aes_ct_collector.sv
// Directed bench for aes_ct_collector with a delay-line stand-in for the AES encryptor.
module tb_aes_ct_collector;
    localparam int LAT = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_en, m_ready, ovf_clr;
    logic [127:0] ct_in, ct_src;
    logic         blk_ready, m_valid, m_last, ovf_flag;
    logic [31:0]  m_data;
    logic [7:0]   ovf_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] ct_tab [6];
    logic [127:0] ct_pipe [LAT];

    typedef struct {
        logic        blk_en;
        logic        m_ready;
        logic        exp_valid;
        logic        exp_last;
        logic [31:0] exp_data;
        logic        exp_ready;
    } vec_t;
    vec_t tbl [17];

    always #5 clk = ~clk;

    aes_ct_collector dut (
        .clk       (clk),
        .rst       (rst),
        .blk_en    (blk_en),
        .ct_in     (ct_in),
        .blk_ready (blk_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .ovf_clr   (ovf_clr),
        .ovf_flag  (ovf_flag),
        .ovf_cnt   (ovf_cnt)
    );

    // Encryptor stand-in: ciphertext emerges LAT edges after the launching enable.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) ct_pipe[i] <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) ct_pipe[i] <= ct_pipe[i-1];
            ct_pipe[0] <= blk_en ? ct_src : '0;
        end
    end
    assign ct_in = ct_pipe[LAT-1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_valid: got no m_valid want m_valid within %0d cycles", budget);
        end
    endtask

    // Drains nblk blocks expected as ct_tab[first..], one word per cycle while valid.
    task automatic collect(input int first, input int nblk, input bit nogap);
        int gaps;
        bit ok;
        gaps = 0;
        m_ready = 1'b1;
        #1;
        for (int b = 0; b < nblk; b++) begin
            for (int w = 0; w < 4; w++) begin
                if (!m_valid) begin
                    if (b != 0 || w != 0) gaps++;
                    wait_valid(60, ok);
                    if (!ok) return;
                end
                chk($sformatf("word b%0d w%0d", first + b, w), m_data, ct_tab[first+b][127-32*w -: 32]);
                chk($sformatf("last b%0d w%0d", first + b, w), m_last, (w == 3));
                tick();
            end
        end
        if (nogap) chk("gaps", gaps, 0);
        m_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        ct_tab[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ct_tab[1] = 128'h0123456789abcdeffedcba9876543210;
        ct_tab[2] = 128'hdeadbeefcafef00d0badc0de8badf00d;
        ct_tab[3] = 128'h11112222333344445555666677778888;
        ct_tab[4] = 128'ha5a5a5a55a5a5a5affff000000ffff00;
        ct_tab[5] = 128'h13579bdf2468ace0fedcba9801234567;

        // Single block: launch at vector 0, words visible vectors 12..15.
        for (int i = 0; i < 17; i++) begin
            tbl[i].blk_en    = (i == 0);
            tbl[i].m_ready   = 1'b1;
            tbl[i].exp_valid = (i >= 12 && i <= 15);
            tbl[i].exp_last  = (i == 15);
            tbl[i].exp_data  = 32'h0;
            tbl[i].exp_ready = 1'b1;
        end
        tbl[12].exp_data = 32'h69c4e0d8;
        tbl[13].exp_data = 32'h6a7b0430;
        tbl[14].exp_data = 32'hd8cdb780;
        tbl[15].exp_data = 32'h70b4c55a;

        rst = 1'b0; blk_en = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0; ct_src = '0;
        #3;
        chk("rst m_valid", m_valid, 0);
        chk("rst m_last", m_last, 0);
        chk("rst m_data", m_data, 0);
        chk("rst ovf_flag", ovf_flag, 0);
        chk("rst ovf_cnt", ovf_cnt, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("post-rst blk_ready", blk_ready, 1);
        tick();

        for (int i = 0; i < 17; i++) begin
            blk_en  = tbl[i].blk_en;
            m_ready = tbl[i].m_ready;
            ct_src  = ct_tab[0];
            #1;
            chk($sformatf("t1 v%0d valid", i), m_valid, tbl[i].exp_valid);
            chk($sformatf("t1 v%0d last", i), m_last, tbl[i].exp_last);
            chk($sformatf("t1 v%0d data", i), m_data, tbl[i].exp_data);
            chk($sformatf("t1 v%0d blk_ready", i), blk_ready, tbl[i].exp_ready);
            tick();
        end
        blk_en = 1'b0;

        // Back-to-back launches stream out with no gaps.
        for (int k = 0; k < 4; k++) begin
            blk_en = 1'b1; ct_src = ct_tab[k];
            tick();
        end
        blk_en = 1'b0;
        collect(0, 4, 1'b1);
        chk("t2 ovf_cnt", ovf_cnt, 0);

        // Backpressure: head word holds while the sink stalls.
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            blk_en = 1'b1; ct_src = ct_tab[k];
            tick();
        end
        blk_en = 1'b0;
        #1;
        chk("t3 blk_ready after 4th", blk_ready, 0);
        for (int i = 0; i < 36; i++) begin
            tick();
            if (i >= 12 && i % 6 == 0) begin
                chk("t3 hold valid", m_valid, 1);
                chk("t3 hold data", m_data, 32'h69c4e0d8);
                chk("t3 hold blk_ready", blk_ready, 0);
            end
        end
        collect(0, 4, 1'b0);
        chk("t3 blk_ready drained", blk_ready, 1);

        // Overflow: six launches into a four-deep FIFO with the sink stalled.
        for (int k = 0; k < 6; k++) begin
            blk_en = 1'b1; ct_src = ct_tab[k];
            tick();
        end
        blk_en = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t4 ovf_flag", ovf_flag, 1);
        chk("t4 ovf_cnt", ovf_cnt, 2);
        collect(0, 4, 1'b0);
        chk("t4 empty", m_valid, 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        #1;
        chk("t4 clr flag", ovf_flag, 0);
        chk("t4 clr cnt", ovf_cnt, 0);

        // Full FIFO: last head word accepted on the edge that pushes block 5.
        for (int t = 0; t <= 22; t++) begin
            blk_en  = (t < 4) || (t == 10);
            ct_src  = (t < 4) ? ct_tab[t] : ct_tab[4];
            m_ready = (t >= 18) && (t <= 21);
            #1;
            if (t == 21) begin
                chk("t5 last word", m_data, ct_tab[0][31:0]);
                chk("t5 last flag", m_last, 1);
            end
            if (t == 22) begin
                chk("t5 valid", m_valid, 1);
                chk("t5 new head", m_data, ct_tab[1][127:96]);
                chk("t5 full blk_ready", blk_ready, 0);
                chk("t5 no drop", ovf_flag, 0);
            end
            tick();
        end
        blk_en = 1'b0;
        collect(1, 4, 1'b0);
        chk("t5 ovf_cnt", ovf_cnt, 0);

        // Reset in the middle of a block, with another block in flight.
        blk_en = 1'b1; ct_src = ct_tab[5];
        tick();
        blk_en = 1'b0;
        m_ready = 1'b1;
        wait_valid(30, ok);
        chk("t6 word0", m_data, ct_tab[5][127:96]);
        blk_en = 1'b1; ct_src = ct_tab[2];
        tick();
        blk_en = 1'b0;
        chk("t6 word1", m_data, ct_tab[5][95:64]);
        rst = 1'b0;
        #1;
        chk("t6 rst m_valid", m_valid, 0);
        chk("t6 rst m_data", m_data, 0);
        chk("t6 rst m_last", m_last, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("t6 blk_ready", blk_ready, 1);
        for (int i = 0; i < 15; i++) tick();
        chk("t6 in-flight discarded", m_valid, 0);
        blk_en = 1'b1; ct_src = ct_tab[4];
        tick();
        blk_en = 1'b0;
        collect(4, 1, 1'b0);
        chk("t6 final empty", m_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
